// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared constants and types for the 4 KB data cache (dcache_4kb).
//   DCACHE_WORDS    : number of 32-bit words in the array
//   DCACHE_IDX_W    : width of the word index
//   DCACHE_IDX_LSB  : lowest byte-address bit that forms the word index
//   DCACHE_ID_MAX_W : widest load/store tag carried in a request
//   dcache_req_t    : one accepted request {valid, is_store, id, word}
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int DCACHE_WORDS    = 1024;
    localparam int DCACHE_IDX_W    = 10;
    localparam int DCACHE_IDX_LSB  = 2;
    localparam int DCACHE_DATA_W   = 32;
    localparam int DCACHE_ID_MAX_W = 32;

    // The id field is sized for the widest tag; narrower tags are
    // zero-extended into it and the top bits are simply never read.
    typedef struct packed {
        logic                       valid;
        logic                       is_store;
        logic [DCACHE_ID_MAX_W-1:0] id;
        logic [DCACHE_DATA_W-1:0]   word;
    } dcache_req_t;

endpackage : mem_pkg

// File: rtl/dcache_4kb_if.sv
// ---------------------------------------------------------------------------
// dcache_4kb_if
//   Request/completion bus between the load/store queue and dcache_4kb.
//   Request side  : memR, memW, ldstID, addr, Wdata   (LSQ -> cache)
//   Completion    : Rdata, ldstID_out, ready_out      (cache -> LSQ)
//   Modports      : master = LSQ side, slave = cache side.
// ---------------------------------------------------------------------------
interface dcache_4kb_if #(
    parameter int ID_W = 4
);

    logic            memR;
    logic            memW;
    logic [ID_W-1:0] ldstID;
    logic [31:0]     addr;
    logic [31:0]     Wdata;
    logic [31:0]     Rdata;
    logic [ID_W-1:0] ldstID_out;
    logic            ready_out;

    modport master (
        output memR,
        output memW,
        output ldstID,
        output addr,
        output Wdata,
        input  Rdata,
        input  ldstID_out,
        input  ready_out
    );

    modport slave (
        input  memR,
        input  memW,
        input  ldstID,
        input  addr,
        input  Wdata,
        output Rdata,
        output ldstID_out,
        output ready_out
    );

endinterface : dcache_4kb_if

// File: rtl/dcache_sram_1kx32.sv
// ---------------------------------------------------------------------------
// dcache_sram_1kx32
//   Synchronous single-port 1024 x 32 RAM.
//   clk   in   clock
//   en    in   access enable (read or write this cycle)
//   we    in   write enable (only meaningful with en)
//   idx   in   word index
//   wdata in   write data
//   q     out  registered read data; on a write it returns the word that was
//              in the array before the write (read-old)
//   The array has no reset: its contents survive a cache reset.
// ---------------------------------------------------------------------------
module dcache_sram_1kx32
    import mem_pkg::*;
(
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [DCACHE_IDX_W-1:0]  idx,
    input  logic [DCACHE_DATA_W-1:0] wdata,
    output logic [DCACHE_DATA_W-1:0] q
);

    logic [DCACHE_DATA_W-1:0] mem_r [DCACHE_WORDS];

    // Array write and read-old registered read port.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_r[idx] <= wdata;
            end
            q <= mem_r[idx];
        end
    end

endmodule : dcache_sram_1kx32

// File: rtl/dcache_4kb.sv
// ---------------------------------------------------------------------------
// dcache_4kb
//   4 KB always-hit data memory for the MEM stage. One load or store is
//   accepted per cycle; each completes exactly LAT cycles after acceptance
//   with a one-cycle ready_out strobe carrying the request tag and data.
//   Parameters:
//     ID_W  width of the load/store tag (1..32)
//     LAT   request-to-completion latency in cycles (1..4)
//   Ports:
//     clk   in   clock, all state on posedge
//     rst   in   asynchronous active-high reset
//     bus   slave side of dcache_4kb_if (memR/memW/ldstID/addr/Wdata in,
//           Rdata/ldstID_out/ready_out out)
// ---------------------------------------------------------------------------
module dcache_4kb
    import mem_pkg::*;
#(
    parameter int ID_W = 4,
    parameter int LAT  = 2
) (
    input  logic          clk,
    input  logic          rst,
    dcache_4kb_if.slave   bus
);

    dcache_req_t              req_s;
    dcache_req_t              req_r;
    logic [DCACHE_IDX_W-1:0]  idx_s;
    logic [DCACHE_DATA_W-1:0] sram_q_s;
    logic [DCACHE_DATA_W-1:0] result_s;
    logic                     unused_s;

    // Request decode: memW wins over memR, so R&W is a store.
    always_comb begin
        req_s          = '0;
        req_s.valid    = bus.memR | bus.memW;
        req_s.is_store = bus.memW;
        req_s.id       = DCACHE_ID_MAX_W'(bus.ldstID);
        req_s.word     = bus.Wdata;
        idx_s          = bus.addr[DCACHE_IDX_LSB +: DCACHE_IDX_W];
    end

    // Byte-offset bits, alias bits above 4 KB and the spare tag bits are
    // intentionally ignored; fold them into one sink.
    assign unused_s = ^{bus.addr, req_r.id};

    dcache_sram_1kx32 u_sram (
        .clk   (clk),
        .en    (req_s.valid),
        .we    (req_s.is_store),
        .idx   (idx_s),
        .wdata (bus.Wdata),
        .q     (sram_q_s)
    );

    // Stage 1: capture the accepted request alongside the RAM read.
    // Reset leaves is_store set with a zero word so the stage-1 result mux
    // yields 0 even though the RAM output register is not reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r.valid    <= 1'b0;
            req_r.is_store <= 1'b1;
            req_r.id       <= '0;
            req_r.word     <= '0;
        end else begin
            req_r.valid <= req_s.valid;
            if (req_s.valid) begin
                req_r.is_store <= req_s.is_store;
                req_r.id       <= req_s.id;
                req_r.word     <= req_s.word;
            end
        end
    end

    // Result word: store data for stores, pre-write array word for loads.
    always_comb begin
        if (req_r.is_store) begin
            result_s = req_r.word;
        end else begin
            result_s = sram_q_s;
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            assign bus.ready_out  = req_r.valid;
            assign bus.ldstID_out = req_r.id[ID_W-1:0];
            assign bus.Rdata      = result_s;
        end else begin : g_pipe
            localparam int DEPTH = LAT - 1;

            logic                     valid_r [DEPTH];
            logic [ID_W-1:0]          id_r    [DEPTH];
            logic [DCACHE_DATA_W-1:0] data_r  [DEPTH];

            // Completion shift pipeline; data/id only advance with a valid
            // entry so the last stage holds the last completed values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        valid_r[k] <= 1'b0;
                        id_r[k]    <= '0;
                        data_r[k]  <= '0;
                    end
                end else begin
                    valid_r[0] <= req_r.valid;
                    if (req_r.valid) begin
                        id_r[0]   <= req_r.id[ID_W-1:0];
                        data_r[0] <= result_s;
                    end
                    for (int k = 1; k < DEPTH; k++) begin
                        valid_r[k] <= valid_r[k-1];
                        if (valid_r[k-1]) begin
                            id_r[k]   <= id_r[k-1];
                            data_r[k] <= data_r[k-1];
                        end
                    end
                end
            end

            assign bus.ready_out  = valid_r[DEPTH-1];
            assign bus.ldstID_out = id_r[DEPTH-1];
            assign bus.Rdata      = data_r[DEPTH-1];
        end
    endgenerate

endmodule : dcache_4kb

// File: tb/tb_dcache_4kb.sv
// ---------------------------------------------------------------------------
// tb_dcache_4kb
//   Directed self-checking bench for dcache_4kb with ID_W=4, LAT=2.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, so a request driven before posedge N completes at the sample
//   following posedge N+1.
// ---------------------------------------------------------------------------
module tb_dcache_4kb;

    localparam int ID_W = 4;
    localparam int LAT  = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dcache_4kb_if #(.ID_W(ID_W)) bus ();

    dcache_4kb #(.ID_W(ID_W), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one full cycle: through the rising edge to the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic w, input logic [ID_W-1:0] id,
                         input logic [31:0] a, input logic [31:0] d);
        bus.memR   = r;
        bus.memW   = w;
        bus.ldstID = id;
        bus.addr   = a;
        bus.Wdata  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        logic [36:0] obs;
        rst = 1'b1;
        idle();
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
            checks++;
            if (obs !== 37'd0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%h want=%h", i, obs, 37'd0);
            end
        end
    endtask

    task automatic test_store_pair();
        logic [36:0] obs;
        drive(1'b0, 1'b1, 4'd1, 32'd40, 32'd9000);
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs[36] !== 1'b0) begin
            failures++;
            $display("FAIL store_early_strobe got=%b want=%b", obs[36], 1'b0);
        end
        drive(1'b0, 1'b1, 4'd2, 32'd44, 32'd9001);
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd1, 32'd9000}) begin
            failures++;
            $display("FAIL store1_done got=%h want=%h", obs, {1'b1, 4'd1, 32'd9000});
        end
        idle();
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd2, 32'd9001}) begin
            failures++;
            $display("FAIL store2_done got=%h want=%h", obs, {1'b1, 4'd2, 32'd9001});
        end
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b0, 4'd2, 32'd9001}) begin
            failures++;
            $display("FAIL idle_hold got=%h want=%h", obs, {1'b0, 4'd2, 32'd9001});
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] obs;
        drive(1'b1, 1'b0, 4'd3, 32'd40, 32'd0);
        step();
        drive(1'b1, 1'b0, 4'd4, 32'd44, 32'd0);
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd3, 32'd9000}) begin
            failures++;
            $display("FAIL load3 got=%h want=%h", obs, {1'b1, 4'd3, 32'd9000});
        end
        idle();
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd4, 32'd9001}) begin
            failures++;
            $display("FAIL load4 got=%h want=%h", obs, {1'b1, 4'd4, 32'd9001});
        end
        step();
        checks++;
        if (bus.ready_out !== 1'b0) begin
            failures++;
            $display("FAIL load_single_strobe got=%b want=%b", bus.ready_out, 1'b0);
        end
    endtask

    task automatic test_alias();
        logic [36:0] obs;
        drive(1'b1, 1'b0, 4'd5, 32'd4136, 32'd0);
        step();
        drive(1'b1, 1'b0, 4'd6, 32'd43, 32'd0);
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd5, 32'd9000}) begin
            failures++;
            $display("FAIL alias_high got=%h want=%h", obs, {1'b1, 4'd5, 32'd9000});
        end
        idle();
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd6, 32'd9000}) begin
            failures++;
            $display("FAIL alias_low got=%h want=%h", obs, {1'b1, 4'd6, 32'd9000});
        end
    endtask

    task automatic test_raw();
        logic [36:0] obs;
        drive(1'b0, 1'b1, 4'd7, 32'd60, 32'h0000_00a5);
        step();
        drive(1'b1, 1'b0, 4'd8, 32'd60, 32'd0);
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd7, 32'h0000_00a5}) begin
            failures++;
            $display("FAIL raw_store got=%h want=%h", obs, {1'b1, 4'd7, 32'h0000_00a5});
        end
        idle();
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd8, 32'h0000_00a5}) begin
            failures++;
            $display("FAIL raw_load got=%h want=%h", obs, {1'b1, 4'd8, 32'h0000_00a5});
        end
    endtask

    task automatic test_rw_both();
        logic [36:0] obs;
        drive(1'b1, 1'b1, 4'd9, 32'd48, 32'd7);
        step();
        drive(1'b1, 1'b0, 4'd10, 32'd48, 32'hdead_beef);
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd9, 32'd7}) begin
            failures++;
            $display("FAIL rw_both_store got=%h want=%h", obs, {1'b1, 4'd9, 32'd7});
        end
        idle();
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd10, 32'd7}) begin
            failures++;
            $display("FAIL rw_both_load got=%h want=%h", obs, {1'b1, 4'd10, 32'd7});
        end
    endtask

    task automatic test_reset_midop();
        logic [36:0] obs;
        drive(1'b0, 1'b1, 4'd11, 32'd52, 32'd5);
        step();
        idle();
        rst = 1'b1;
        #1;
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== 37'd0) begin
            failures++;
            $display("FAIL midop_async_clear got=%h want=%h", obs, 37'd0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (bus.ready_out !== 1'b0) begin
                failures++;
                $display("FAIL midop_dropped cycle=%0d got=%b want=%b", i, bus.ready_out, 1'b0);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.ready_out !== 1'b0) begin
            failures++;
            $display("FAIL midop_after_release got=%b want=%b", bus.ready_out, 1'b0);
        end
        drive(1'b1, 1'b0, 4'd12, 32'd52, 32'd0);
        step();
        idle();
        step();
        obs = {bus.ready_out, bus.ldstID_out, bus.Rdata};
        checks++;
        if (obs !== {1'b1, 4'd12, 32'd5}) begin
            failures++;
            $display("FAIL midop_store_kept got=%h want=%h", obs, {1'b1, 4'd12, 32'd5});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_store_pair();
        test_back_to_back();
        test_alias();
        test_raw();
        test_rw_both();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dcache_4kb
